// File: rtl/complex_accum_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | complex_accum_sequencer: feeds a stream of complex elements through an     |
// | external pipelined complex adder/subtractor and returns the running total. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module complex_accum_sequencer #(
  parameter int ADDER_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  len,
  input  logic        op,
  output logic        busy,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] add_A,
  output logic [63:0] add_B,
  output logic        add_op,
  output logic        add_ce,
  output logic        add_strobe,
  input  logic [63:0] add_result,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CW = $clog2(ADDER_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    rem_q, rem_d;
  logic          op_q, op_d;
  logic [63:0]   acc_q, acc_d;
  logic [63:0]   elem_q, elem_d;
  logic [CW-1:0] wcnt_q, wcnt_d;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    acc_d   = acc_q;
    elem_d  = elem_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = (len == 4'd0) ? 5'd16 : {1'b0, len};
          op_d    = op;
          acc_d   = 64'h0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          elem_d  = in_data;
          wcnt_d  = CW'(ADDER_LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - CW'(1);
        // The last wait cycle is the one where the adder output is valid.
        if (wcnt_q == CW'(1)) begin
          acc_d   = add_result;
          rem_d   = rem_q - 5'd1;
          state_d = (rem_q == 5'd1) ? S_OUT : S_LOAD;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= 5'd0;
      op_q    <= 1'b0;
      acc_q   <= 64'h0;
      elem_q  <= 64'h0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      elem_q  <= elem_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign in_ready   = (state_q == S_LOAD);
  assign add_ce     = (state_q == S_WAIT);
  assign add_strobe = (state_q == S_WAIT) && (wcnt_q == CW'(1));
  assign out_valid  = (state_q == S_OUT);
  assign add_A      = acc_q;
  assign add_B      = elem_q;
  assign add_op     = op_q;
  assign out_data   = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_complex_accum_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_complex_accum_sequencer: scoreboard bench with a behavioural adder.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_complex_accum_sequencer;

  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic        op;
  logic        busy;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] add_A;
  logic [63:0] add_B;
  logic        add_op;
  logic        add_ce;
  logic        add_strobe;
  logic [63:0] add_result;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  complex_accum_sequencer #(.ADDER_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .op         (op),
    .busy       (busy),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .add_A      (add_A),
    .add_B      (add_B),
    .add_op     (add_op),
    .add_ce     (add_ce),
    .add_strobe (add_strobe),
    .add_result (add_result),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single-precision <-> real conversion, exact for the small integers used here.
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'h0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [63:0] cadd(input logic [63:0] a, input logic [63:0] b, input logic o);
    real re, im;
    re = o ? f2r(a[63:32]) - f2r(b[63:32]) : f2r(a[63:32]) + f2r(b[63:32]);
    im = o ? f2r(a[31:0]) - f2r(b[31:0]) : f2r(a[31:0]) + f2r(b[31:0]);
    return {r2f(re), r2f(im)};
  endfunction

  function automatic logic [63:0] rnd_elem();
    int a, b;
    a = int'($urandom_range(16, 0)) - 8;
    b = int'($urandom_range(16, 0)) - 8;
    return {r2f(real'(a)), r2f(real'(b))};
  endfunction

  // External adder: LAT-1 enabled pipeline stages behind a combinational add.
  logic [63:0] pipe [LAT-1];
  always @(posedge clk) begin
    if (add_ce) begin
      pipe[0] <= cadd(add_A, add_B, add_op);
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign add_result = pipe[LAT-2];

  logic [63:0] exp_q[$];
  int          exp_strb_q[$];
  int          exp_busy_q[$];

  int          strb_cnt = 0;
  int          busy_cnt = 0;
  int          since = 0;
  bit          armed = 0;
  logic [63:0] last_elem = 64'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      strb_cnt = 0;
      busy_cnt = 0;
      armed    = 0;
    end else begin
      if (busy) busy_cnt++;
      if (armed) since++;
      if (add_strobe) begin
        strb_cnt++;
        chk("strobe_latency", 64'(since), 64'(LAT));
        chk("strobe_addB", add_B, last_elem);
        armed = 0;
      end
      if (in_ready && in_valid) begin
        armed     = 1;
        since     = 0;
        last_elem = in_data;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected no transfer", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
          chk("strobe_count", 64'(strb_cnt), 64'(exp_strb_q.pop_front()));
          chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy_q.pop_front()));
        end
        strb_cnt = 0;
        busy_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input bit want_out, output bit ok);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if ((want_out ? out_valid : in_ready) === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got 0 expected 1 within 200 cycles",
               want_out ? "out_valid" : "in_ready");
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_ctrl"}, 64'({busy, in_ready, add_ce, add_strobe, out_valid, add_op}), 64'h0);
    chk({name, "_addA"}, add_A, 64'h0);
    chk({name, "_addB"}, add_B, 64'h0);
    chk({name, "_out"}, out_data, 64'h0);
  endtask

  logic [63:0] elems [16];

  task automatic run_job(input logic [3:0] l, input logic o, input int gap,
                         input int stall, input bit poke);
    int          n;
    real         sr, si;
    bit          ok;
    logic [63:0] expv;
    n  = (l == 4'd0) ? 16 : int'(l);
    sr = 0.0;
    si = 0.0;
    for (int i = 0; i < n; i++) begin
      sr += f2r(elems[i][63:32]);
      si += f2r(elems[i][31:0]);
    end
    if (o) begin
      sr = -sr;
      si = -si;
    end
    expv = {r2f(sr), r2f(si)};
    exp_q.push_back(expv);
    exp_strb_q.push_back(n);
    exp_busy_q.push_back(n * (1 + LAT) + 1 + n * gap + stall);

    start = 1'b1; len = l; op = o;
    tick();
    start = 1'b0; len = 4'($urandom); op = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      wait_for(1'b0, ok);
      if (!ok) return;
      for (int g = 0; g < gap; g++) begin
        chk("load_stall_ready", 64'({in_ready, busy}), 64'h3);
        tick();
      end
      in_valid = 1'b1;
      in_data  = elems[i];
      tick();
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      if (poke && i == 0) begin
        start = 1'b1; len = 4'($urandom); op = ~o;
        tick();
        start = 1'b0;
      end
    end
    wait_for(1'b1, ok);
    if (!ok) return;
    for (int s = 0; s < stall; s++) begin
      chk("out_stall_valid", 64'(out_valid), 64'h1);
      chk("out_stall_data", out_data, expv);
      if (poke && s == 0) start = 1'b1;
      tick();
      start = 1'b0;
    end
    out_ready = 1'b1;
    start     = poke;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("idle_after_out", 64'(busy), 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0; len = 4'd0; op = 1'b0;
    in_data = 64'h0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    elems[0] = 64'h3F800000_3F800000;
    elems[1] = 64'h40000000_40000000;
    run_job(4'd2, 1'b0, 0, 0, 1'b0);
    run_job(4'd2, 1'b1, 0, 0, 1'b0);

    for (int i = 0; i < 16; i++) elems[i] = 64'h3F800000_00000000;
    run_job(4'd0, 1'b0, 0, 0, 1'b0);

    elems[0] = rnd_elem();
    run_job(4'd1, 1'b0, 10, 5, 1'b0);

    for (int i = 0; i < 3; i++) elems[i] = rnd_elem();
    run_job(4'd3, 1'b0, 0, 3, 1'b1);

    // Job aborted by reset while the second element is in the adder.
    start = 1'b1; len = 4'd2; op = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_for(1'b0, ok);
      in_valid = 1'b1;
      in_data  = rnd_elem();
      tick();
      in_valid = 1'b0;
    end
    tick();
    rst_n = 1'b0;
    tick();
    check_idle("mid_reset");
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");
    elems[0] = rnd_elem();
    run_job(4'd1, 1'b0, 0, 0, 1'b0);

    repeat (12) begin
      logic [3:0] l;
      l = 4'($urandom);
      for (int i = 0; i < 16; i++) elems[i] = rnd_elem();
      run_job(l, 1'($urandom), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 1'b0);
    end

    repeat (5) tick();
    chk("pending_results", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/complex_accum_sequencer.md
COMPLEX_ACCUM_SEQUENCER -- requirements
Module: complex_accum_sequencer

Interface
REQ-001 The block SHALL have parameter ADDER_LATENCY, default 4, giving the number of cycles from operand issue to a valid adder result.
REQ-002 The block SHALL have a single clock; reset SHALL be synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  begin an accumulation job; sampled only in IDLE.
REQ-006 len  input  4  element count; 1..15 literal, 0 means 16.
REQ-007 op  input  1  0 = add, 1 = subtract; latched at start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 in_data  input  64  complex element; real = [63:32], imaginary = [31:0], IEEE-754 single each.
REQ-010 in_valid / in_ready  input / output  1 each  element handshake.
REQ-011 add_A, add_B  output  64 each  operands to the external complex adder/subtractor.
REQ-012 add_op  output  1  latched op, forwarded unchanged.
REQ-013 add_ce  output  1  adder clock enable.
REQ-014 add_strobe  output  1  result-capture strobe to the adder's hold-control input.
REQ-015 add_result  input  64  complex adder result.
REQ-016 out_data  output  64  final accumulated complex value.
REQ-017 out_valid / out_ready  output / input  1 each  result handshake.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, WAIT and OUT.
REQ-019 IDLE: start=1 SHALL latch len (0 maps to 16) into a 5-bit remaining counter, latch op, clear acc to 64'h0, and enter LOAD next cycle.
REQ-020 start SHALL be ignored in LOAD, WAIT and OUT; a job SHALL NOT be restarted mid-operation.
REQ-021 LOAD SHALL assert in_ready=1; in_valid=1 in that state SHALL register in_data into elem_reg, load wait_cnt=ADDER_LATENCY, and enter WAIT.
REQ-022 in_ready SHALL be 0 in every state other than LOAD.
REQ-023 add_A SHALL equal acc and add_B SHALL equal elem_reg at all times; both SHALL remain stable throughout WAIT.
REQ-024 add_ce SHALL be 1 only in WAIT.
REQ-025 In WAIT, wait_cnt SHALL decrement each cycle.
REQ-026 add_strobe SHALL be high for exactly one cycle: the WAIT cycle in which wait_cnt==1, which is ADDER_LATENCY cycles after the acceptance cycle.
REQ-027 In the add_strobe cycle, acc SHALL take add_result and remaining SHALL decrement; if the new remaining==0 the FSM SHALL enter OUT, otherwise LOAD.
REQ-028 The block SHALL compute acc = 0 op e1 op e2 ... op eN (subtract gives -(e1+...+eN)); the real and imaginary halves are never mixed.
REQ-029 Per-element cost SHALL be 1 accept cycle + ADDER_LATENCY cycles; there is no operand interleaving.
REQ-030 OUT SHALL drive out_valid=1 and out_data=acc, holding both stable until out_ready=1; in that cycle the FSM SHALL return to IDLE.
REQ-031 out_ready=1 in the first OUT cycle SHALL complete the transfer in one cycle; start in that same cycle SHALL be ignored.
REQ-032 in_valid stalls in LOAD SHALL be unbounded with no state change; add_result SHALL be ignored outside the strobe cycle.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, acc=0, elem_reg=0, remaining=0, wait_cnt=0, op latch=0.
REQ-034 Reset SHALL take priority over all other inputs, including in any state mid-job; the job SHALL be discarded without an output transfer.
REQ-035 During and after reset, busy, in_ready, add_ce, add_strobe, out_valid and add_op SHALL be 0, and add_A, add_B and out_data SHALL be 64'h0.

Verification
REQ-036 len=2, op=0, elements 0x3F800000_3F800000, 0x40000000_40000000, model adder -> out_data=0x40400000_40400000; exactly 2 add_strobe pulses.
REQ-037 len=2, op=1, same elements -> out_data=0xC0400000_C0400000.
REQ-038 len=0, 16 elements of 0x3F800000_00000000 -> out_data=0x41800000_00000000 (16.0+0j); busy high for 16*(1+ADDER_LATENCY)+1 cycles after start.
REQ-039 in_valid withheld 10 cycles in LOAD, then out_ready held low 5 cycles in OUT -> no state change during the stalls, in_ready and out_valid held high, out_data stable.
REQ-040 rst_n pulsed low during WAIT of element 2 -> next cycle IDLE, all outputs 0, no out_valid; a fresh len=1 job then returns that element exactly.
REQ-041 start pulsed during WAIT and during OUT -> ignored; remaining and acc unaffected; only one result is produced.
